// File: rtl/imem_responder_if.sv
// Fetch request / instruction response bundle between the fetch stage
// (master) and the instruction memory responder (slave).
interface imem_responder_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        stall;
    logic        inst_mem_is_valid;
    logic [31:0] inst_mem_read_data;
    logic [31:0] inst_data_future;
    logic        resp_error;

    modport master (
        output req_valid,
        output req_addr,
        output stall,
        input  req_ready,
        input  inst_mem_is_valid,
        input  inst_mem_read_data,
        input  inst_data_future,
        input  resp_error
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  stall,
        output req_ready,
        output inst_mem_is_valid,
        output inst_mem_read_data,
        output inst_data_future,
        output resp_error
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: word array with side load port and a
// fixed-latency, stallable response pipeline returning word and word+4.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1,
    parameter logic [31:0] NOP         = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   reset,
    imem_responder_if.slave        bus,
    input  logic                   load_en,
    input  logic [31:0]            load_addr,
    input  logic [31:0]            load_data,
    output logic                   busy
);
    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [29:0] BASE_W  = BASE[31:2];
    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
    localparam logic [29:0] LAST_W  = 30'(DEPTH_WORDS - 1);

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
        logic [31:0] future;
    } resp_t;

    localparam resp_t RESP_RST = '{
        valid:  1'b0,
        err:    1'b0,
        data:   NOP,
        future: NOP
    };

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0]   req_woff;
    logic          req_ok;
    logic          req_last;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] req_nxt;
    logic          accept;
    resp_t         in_ent;

    logic [29:0]   ld_woff;
    logic          ld_ok;

    resp_t         stg [LATENCY];
    resp_t         src [LATENCY];

    // Word offsets are computed on [31:2]; BASE is word aligned.
    assign req_woff = bus.req_addr[31:2] - BASE_W;
    assign req_ok   = (bus.req_addr[1:0] == 2'b00)
                   && (bus.req_addr[31:2] >= BASE_W)
                   && (req_woff < DEPTH_W);
    assign req_last = (req_woff == LAST_W);
    assign req_idx  = req_woff[AW-1:0];
    assign req_nxt  = req_idx + AW'(1);

    assign bus.req_ready = !bus.stall && !load_en;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        in_ent       = RESP_RST;
        in_ent.valid = accept;
        in_ent.err   = 1'b1;
        if (req_ok) begin
            in_ent.err  = 1'b0;
            in_ent.data = mem[req_idx];
            if (!req_last) begin
                in_ent.future = mem[req_nxt];
            end
        end
    end

    assign ld_woff = load_addr[31:2] - BASE_W;
    assign ld_ok   = (load_addr[1:0] == 2'b00)
                  && (load_addr[31:2] >= BASE_W)
                  && (ld_woff < DEPTH_W);

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (load_en && ld_ok) begin
            mem[ld_woff[AW-1:0]] <= load_data;
        end
    end

    for (genvar i = 0; i < LATENCY; i++) begin : g_src
        if (i == 0) begin : g_head
            assign src[i] = in_ent;
        end else begin : g_tail
            assign src[i] = stg[i-1];
        end
    end

    // Payload only moves with a valid entry so bubbles keep the last data.
    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stg[i] <= RESP_RST;
            end else if (!bus.stall) begin
                if (src[i].valid) begin
                    stg[i] <= src[i];
                end else begin
                    stg[i].valid <= 1'b0;
                end
            end
        end
    end

    assign bus.inst_mem_is_valid  = stg[LATENCY-1].valid;
    assign bus.inst_mem_read_data = stg[LATENCY-1].data;
    assign bus.inst_data_future   = stg[LATENCY-1].future;
    assign bus.resp_error         = stg[LATENCY-1].err;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            busy = busy | stg[i].valid;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: LATENCY=1 and LATENCY=3 instances share stimulus
// and are checked every cycle against a tagged-request reference model.
module tb_imem_responder;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 1024;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr  = '0;
    logic        stall     = 1'b0;
    logic        load_en   = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        busy1;
    logic        busy3;
    bit          checking  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    imem_responder_if b1 ();
    imem_responder_if b3 ();

    assign b1.req_valid = req_valid;
    assign b1.req_addr  = req_addr;
    assign b1.stall     = stall;
    assign b3.req_valid = req_valid;
    assign b3.req_addr  = req_addr;
    assign b3.stall     = stall;

    imem_responder #(.LATENCY(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (b1),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy1)
    );

    imem_responder #(.LATENCY(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .bus       (b3),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .busy      (busy3)
    );

    always #5 clk = ~clk;

    // Reference model: every accepted request is stored under the count of
    // non-stalled edges at which it was accepted; a latency-L consumer sees
    // it once L-1 further non-stalled edges have passed.
    typedef struct {
        logic        v;
        int          tag;
        logic [31:0] d;
        logic [31:0] f;
        logic        e;
    } ent_t;

    ent_t        tbl  [64];
    logic [31:0] mmem [DEPTH];
    int          adv = 0;
    logic [31:0] last_d [2] = '{NOP, NOP};
    logic [31:0] last_f [2] = '{NOP, NOP};
    logic        last_e [2] = '{1'b0, 1'b0};

    function automatic ent_t lookup(input logic [31:0] a);
        ent_t   r;
        longint idx;
        r.v   = 1'b1;
        r.tag = 0;
        r.d   = NOP;
        r.f   = NOP;
        r.e   = 1'b1;
        idx   = longint'(a) / 4;
        if ((a % 4) == 0 && idx < DEPTH) begin
            r.e = 1'b0;
            r.d = mmem[int'(idx)];
            if (idx + 1 < DEPTH) r.f = mmem[int'(idx) + 1];
        end
        return r;
    endfunction

    function automatic bit exp_entry(input int lat, output ent_t e);
        int t;
        t = adv - lat + 1;
        e = tbl[((t % 64) + 64) % 64];
        return e.v && (e.tag == t);
    endfunction

    function automatic bit exp_busy(input int lat);
        bit   b;
        ent_t e;
        int   t;
        b = 1'b0;
        for (int j = 0; j < lat; j++) begin
            t = adv - j;
            e = tbl[((t % 64) + 64) % 64];
            if (e.v && e.tag == t) b = 1'b1;
        end
        return b;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) tbl[i].v = 1'b0;
            for (int k = 0; k < 2; k++) begin
                last_d[k] = NOP;
                last_f[k] = NOP;
                last_e[k] = 1'b0;
            end
        end else if (!stall) begin
            adv++;
            if (req_valid && !load_en) begin
                tbl[adv % 64]     = lookup(req_addr);
                tbl[adv % 64].tag = adv;
            end
        end
    end

    always @(posedge clk) begin
        if (load_en && (load_addr % 4) == 0 && load_addr < 32'(4 * DEPTH))
            mmem[load_addr / 4] = load_data;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic get_out(input int lat, output logic v,
                           output logic [31:0] d, output logic [31:0] f,
                           output logic e, output logic b, output logic r);
        if (lat == 1) begin
            v = b1.inst_mem_is_valid;
            d = b1.inst_mem_read_data;
            f = b1.inst_data_future;
            e = b1.resp_error;
            b = busy1;
            r = b1.req_ready;
        end else begin
            v = b3.inst_mem_is_valid;
            d = b3.inst_mem_read_data;
            f = b3.inst_data_future;
            e = b3.resp_error;
            b = busy3;
            r = b3.req_ready;
        end
    endtask

    task automatic check_dut(input int k, input int lat);
        ent_t        e;
        bit          v;
        logic        av, ae, ab, ar;
        logic [31:0] ad, af;
        v = exp_entry(lat, e);
        if (v) begin
            last_d[k] = e.d;
            last_f[k] = e.f;
            last_e[k] = e.e;
        end
        get_out(lat, av, ad, af, ae, ab, ar);
        if (checking) begin
            chk($sformatf("L%0d valid", lat), 32'(av), 32'(v));
            chk($sformatf("L%0d data", lat), ad, last_d[k]);
            chk($sformatf("L%0d future", lat), af, last_f[k]);
            chk($sformatf("L%0d error", lat), 32'(ae), 32'(last_e[k]));
            chk($sformatf("L%0d busy", lat), 32'(ab), 32'(exp_busy(lat)));
            chk($sformatf("L%0d ready", lat), 32'(ar),
                32'(!stall && !load_en));
        end
    endtask

    always @(posedge clk) begin
        #2;
        check_dut(0, 1);
        check_dut(1, 3);
    end

    task automatic expect_l(input int lat, input string name, input logic v,
                            input logic [31:0] d, input logic [31:0] f,
                            input logic e, input logic b);
        logic        av, ae, ab, ar;
        logic [31:0] ad, af;
        get_out(lat, av, ad, af, ae, ab, ar);
        chk({name, " valid"}, 32'(av), 32'(v));
        chk({name, " data"}, ad, d);
        chk({name, " future"}, af, f);
        chk({name, " error"}, 32'(ae), 32'(e));
        chk({name, " busy"}, 32'(ab), 32'(b));
    endtask

    task automatic cyc(input logic v, input logic [31:0] a, input logic s);
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        stall     = s;
        load_en   = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b0;
        stall     = 1'b0;
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
    endtask

    task automatic obs();
        @(posedge clk);
        #3;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = (32'($urandom_range(0, 1023)) << 2)
                         | 32'($urandom_range(1, 3));
            1:       a = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            2:       a = $urandom;
            3, 4:    a = 32'($urandom_range(1020, 1023)) << 2;
            default: a = 32'($urandom_range(0, 31)) << 2;
        endcase
        return a;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        checking = 1'b1;
        #1;
        expect_l(1, "reset L1", 1'b0, NOP, NOP, 1'b0, 1'b0);
        expect_l(3, "reset L3", 1'b0, NOP, NOP, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) ld(32'(i * 4), $urandom);
        ld(32'h0, 32'h00500093);
        ld(32'h4, 32'h00A00113);
        ld(32'h8, 32'h002081B3);
        ld(32'hC, 32'h0000006F);
        ld(32'hFFC, 32'h12345678);
        cyc(1'b0, 32'h0, 1'b0);

        // back-to-back fetch, latency 1
        cyc(1'b1, 32'h0, 1'b0);
        obs();
        expect_l(1, "b2b a0", 1'b1, 32'h00500093, 32'h00A00113, 1'b0, 1'b1);
        cyc(1'b1, 32'h4, 1'b0);
        obs();
        expect_l(1, "b2b a4", 1'b1, 32'h00A00113, 32'h002081B3, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0);
        obs();
        expect_l(1, "b2b idle", 1'b0, 32'h00A00113, 32'h002081B3, 1'b0, 1'b0);
        expect_l(3, "b2b L3 a0", 1'b1, 32'h00500093, 32'h00A00113, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 32'h0, 1'b0);

        // latency 3 timing
        cyc(1'b1, 32'h8, 1'b0);
        obs();
        expect_l(3, "lat3 e1", 1'b0, 32'h00A00113, 32'h002081B3, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0);
        obs();
        expect_l(3, "lat3 e2", 1'b0, 32'h00A00113, 32'h002081B3, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0);
        obs();
        expect_l(3, "lat3 e3", 1'b1, 32'h002081B3, 32'h0000006F, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0);
        obs();
        expect_l(3, "lat3 e4", 1'b0, 32'h002081B3, 32'h0000006F, 1'b0, 1'b0);

        // error and boundary fetches
        cyc(1'b1, 32'h6, 1'b0);
        obs();
        expect_l(1, "misaligned", 1'b1, NOP, NOP, 1'b1, 1'b1);
        cyc(1'b1, 32'h1000, 1'b0);
        obs();
        expect_l(1, "out of range", 1'b1, NOP, NOP, 1'b1, 1'b1);
        cyc(1'b1, 32'hFFC, 1'b0);
        obs();
        expect_l(1, "last word", 1'b1, 32'h12345678, NOP, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 32'h0, 1'b0);

        // stall holds the presented response
        cyc(1'b1, 32'h0, 1'b0);
        obs();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h4, 1'b1);
            obs();
            expect_l(1, "stall hold", 1'b1, 32'h00500093, 32'h00A00113,
                     1'b0, 1'b1);
            chk("stall ready", 32'(b1.req_ready), 32'h0);
        end
        cyc(1'b0, 32'h0, 1'b0);
        obs();
        expect_l(1, "stall release", 1'b0, 32'h00500093, 32'h00A00113,
                 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 32'h0, 1'b0);

        // load behind an in-flight fetch, then reset mid-flight
        cyc(1'b1, 32'h0, 1'b0);
        ld(32'h0, 32'hDEADBEEF);
        cyc(1'b1, 32'h4, 1'b0);
        obs();
        expect_l(3, "inflight L3", 1'b1, 32'h00500093, 32'h00A00113,
                 1'b0, 1'b1);
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        expect_l(1, "midreset L1", 1'b0, NOP, NOP, 1'b0, 1'b0);
        expect_l(3, "midreset L3", 1'b0, NOP, NOP, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, 32'h0, 1'b0);
        obs();
        expect_l(1, "refetch", 1'b1, 32'hDEADBEEF, 32'h00A00113, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                reset     = 1'b1;
                req_valid = 1'b0;
                stall     = 1'b0;
                load_en   = 1'b0;
            end else begin
                reset     = 1'b0;
                stall     = ($urandom_range(0, 4) == 0);
                load_en   = ($urandom_range(0, 9) == 0);
                req_valid = ($urandom_range(0, 2) != 0);
                req_addr  = rand_addr();
                load_addr = rand_addr();
                load_data = $urandom;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) cyc(1'b0, 32'h0, 1'b0);
        obs();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
